// File: rtl/ibus_responder_if.sv
// Fetch-side handshake between the fetch stage (master) and the
// instruction responder (slave).
interface ibus_responder_if;
  logic [31:0] ibus_addr;
  logic        valid;
  logic        ready;
  logic [31:0] ibus_instr;
  logic        ibus_rvalid;
  logic        ibus_err;

  modport master (
    output ibus_addr, valid,
    input  ready, ibus_instr, ibus_rvalid, ibus_err
  );

  modport slave (
    input  ibus_addr, valid,
    output ready, ibus_instr, ibus_rvalid, ibus_err
  );
endinterface

// File: rtl/ibus_responder.sv
// Instruction-bus responder: accepts fetches, reads a word-addressed RAM
// after WAIT_CYCLES stall cycles and returns the word with a one-cycle
// rvalid strobe. Side-band load port writes the RAM in any state.
// Optional macro IBUS_FAULT_CHECK_EN: misaligned or out-of-range fetches
// return 0 with ibus_err set instead of reading the RAM.
//
// state | meaning
// IDLE  | no access in flight, ready high
// WAIT  | stalling for the remaining wait cycles, ready low
// RESP  | response strobe cycle, ready high (pipelined accept allowed)
module ibus_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           rstf,
  ibus_responder_if.slave                bus,
  input  logic                           load_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic        ready_q;
  logic        rvalid_q;
  logic [31:0] instr_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          issue;
  logic [31:0]   rd_addr;
  logic [AW-1:0] rd_idx;
  logic          rd_fault;

  assign accept = bus.valid && ready_q;

  // Select the address being read: live bus address for zero-wait
  // accepts, the latched one once the wait counter expires.
  always_comb begin
    rd_addr = (state == WAIT) ? addr_q : bus.ibus_addr;
    rd_idx  = rd_addr[AW+1:2];
    issue   = ((state == WAIT) && (cnt == 4'd1)) || (accept && (WAIT_CYCLES == 0));
  end

`ifdef IBUS_FAULT_CHECK_EN
  // Misaligned or beyond the RAM: answered with an error, RAM untouched.
  always_comb begin
    rd_fault = (rd_addr[1:0] != 2'b00) || ((rd_addr >> (AW + 2)) != 32'd0);
  end
`else
  logic unused_addr_bits;
  // Byte offset and high address bits are ignored; addresses wrap.
  always_comb begin
    rd_fault = 1'b0;
  end
  assign unused_addr_bits = ^{rd_addr[1:0], rd_addr[31:AW+2]};
`endif

  // Load port write; RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
  end

  // Handshake FSM with registered ready/rvalid and the read data register.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      addr_q   <= 32'd0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      instr_q  <= NOP;
      err_q    <= 1'b0;
    end else begin
      if (issue) begin
        instr_q <= rd_fault ? 32'h0000_0000 : mem[rd_idx];
        err_q   <= rd_fault;
      end
      unique case (state)
        IDLE, RESP: begin
          if (accept) begin
            addr_q <= bus.ibus_addr;
            cnt    <= WAIT_INIT;
            if (WAIT_CYCLES > 0) begin
              state    <= WAIT;
              ready_q  <= 1'b0;
              rvalid_q <= 1'b0;
            end else begin
              state    <= RESP;
              ready_q  <= 1'b1;
              rvalid_q <= 1'b1;
            end
          end else begin
            state    <= IDLE;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= RESP;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          ready_q  <= 1'b1;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.ibus_rvalid = rvalid_q;
  assign bus.ibus_instr  = instr_q;
  assign bus.ibus_err    = err_q;
endmodule
